// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
//   Shared constants and elaboration-time helpers for the pipelined carry-save
//   reduction tree (csa_tree_pipe / csa_level).
//
//   MAX_IN / MIN_IN  : legal operand-count range per beat.
//   csa_owidth       : output width, OWIDTH = WIDTH + GUARD_BITS.
//   csa_next_count   : operand count after one 3:2 level, 2*(n/3) + n%3.
//   csa_levels       : number of 3:2 levels needed to reach two operands.
//   csa_count_at     : operand count entering a given level.
//
//   No configuration macros are used in this file.
// ---------------------------------------------------------------------------
package csa_pkg;

  localparam int MAX_IN = 9;
  localparam int MIN_IN = 3;

  function automatic int csa_owidth(input int width, input int guard_bits);
    return width + guard_bits;
  endfunction

  function automatic int csa_next_count(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Gives 1,2,3,3,4,4,4 for n = 3..9. The loop bound only has to exceed the
  // deepest tree, so MAX_IN is a safe ceiling.
  function automatic int csa_levels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (c > 2) begin
        c = csa_next_count(c);
        l++;
      end
    end
    return l;
  endfunction

  function automatic int csa_count_at(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < lvl) begin
        c = csa_next_count(c);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/csa_level.sv
// ---------------------------------------------------------------------------
// csa_level
//   One registered 3:2 carry-save reduction level with valid/ready handshake.
//   Input operands are grouped in threes from index 0; each full triple feeds
//   one carry-save adder. The output list is ordered: all CSA sums, then all
//   CSA carries (already shifted left by one), then the 1 or 2 leftover
//   operands passed straight through.
//
//   Parameters
//     N_IN    operand count entering this level
//     OWIDTH  width of every operand (modulo 2^OWIDTH arithmetic)
//     TAG_W   sideband tag width
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     clr               synchronous clear of the valid bit
//     in_valid/in_ready upstream handshake
//     in_data, in_tag   N_IN operands packed [k*OWIDTH +: OWIDTH], tag
//     out_valid/out_ready downstream handshake
//     out_data, out_tag N_OUT reduced operands, tag
//
//   No configuration macros are used in this file.
// ---------------------------------------------------------------------------
module csa_level
  import csa_pkg::*;
#(
  parameter  int N_IN   = 5,
  parameter  int OWIDTH = 35,
  parameter  int TAG_W  = 4,
  localparam int N_OUT  = csa_next_count(N_IN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN*OWIDTH-1:0]    in_data,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT*OWIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int N_TRI  = N_IN / 3;
  localparam int N_PASS = N_IN % 3;

  function automatic logic [OWIDTH-1:0] csa_sum(input logic [OWIDTH-1:0] a,
                                                input logic [OWIDTH-1:0] b,
                                                input logic [OWIDTH-1:0] c);
    return a ^ b ^ c;
  endfunction

  // Majority carry moved to the next weight; the bit leaving the MSB is
  // dropped so the pair stays modulo 2^OWIDTH.
  function automatic logic [OWIDTH-1:0] csa_carry(input logic [OWIDTH-1:0] a,
                                                  input logic [OWIDTH-1:0] b,
                                                  input logic [OWIDTH-1:0] c);
    logic [OWIDTH-1:0] maj;
    maj = (a & b) | (a & c) | (b & c);
    return maj << 1;
  endfunction

  logic [N_OUT*OWIDTH-1:0] red;

  for (genvar t = 0; t < N_TRI; t++) begin : g_csa
    assign red[t*OWIDTH +: OWIDTH] =
      csa_sum(in_data[(3*t)*OWIDTH +: OWIDTH],
              in_data[(3*t+1)*OWIDTH +: OWIDTH],
              in_data[(3*t+2)*OWIDTH +: OWIDTH]);
    assign red[(N_TRI+t)*OWIDTH +: OWIDTH] =
      csa_carry(in_data[(3*t)*OWIDTH +: OWIDTH],
                in_data[(3*t+1)*OWIDTH +: OWIDTH],
                in_data[(3*t+2)*OWIDTH +: OWIDTH]);
  end

  for (genvar p = 0; p < N_PASS; p++) begin : g_pass
    assign red[(2*N_TRI+p)*OWIDTH +: OWIDTH] = in_data[(3*N_TRI+p)*OWIDTH +: OWIDTH];
  end

  // ---- stage p0: reduced operands and tag registered ----
  logic                    vld_p0;
  logic [N_OUT*OWIDTH-1:0] data_p0;
  logic [TAG_W-1:0]        tag_p0;

  // Load when empty or when the current contents leave this same cycle.
  assign in_ready = !vld_p0 || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      tag_p0  <= '0;
    end else begin
      if (clr) begin
        vld_p0 <= 1'b0;
      end else if (in_ready) begin
        vld_p0 <= in_valid;
      end
      if (in_valid && in_ready) begin
        data_p0 <= red;
        tag_p0  <= in_tag;
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_tag   = tag_p0;

endmodule

// File: rtl/csa_tree_pipe.sv
// ---------------------------------------------------------------------------
// csa_tree_pipe
//   Pipelined Dadda-style carry-save reduction of NUM_IN operands of WIDTH
//   bits down to a redundant sum/carry pair of OWIDTH = WIDTH + GUARD_BITS
//   bits. One registered csa_level per reduction level (L levels, L = 1..4
//   for NUM_IN = 3..9). Streaming valid/ready on both sides with a sideband
//   tag that travels in lockstep with the data.
//
//   Parameters
//     WIDTH       operand width
//     NUM_IN      operands per beat, 3..9 (anything else fails elaboration)
//     GUARD_BITS  extra MSBs of headroom
//     SIGNED      1 = sign-extend operands to OWIDTH, 0 = zero-extend
//     TAG_W       sideband tag width
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     clr                  synchronous clear of every in-flight beat
//     in_valid/in_ready    input handshake (in_ready low during clr)
//     in_data              operand k at [k*WIDTH +: WIDTH]
//     in_tag               sideband tag
//     out_valid/out_ready  output handshake
//     out_sum, out_carry   redundant pair; out_carry already weighted
//     out_tag              tag of the presented result
//     out_res              out_sum + out_carry (only with CSA_FINAL_CPA_EN)
//
//   Configuration macro
//     CSA_FINAL_CPA_EN  adds a registered carry-propagate stage producing
//                       out_res; latency grows from L to L+1.
// ---------------------------------------------------------------------------
module csa_tree_pipe
  import csa_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int NUM_IN     = 5,
  parameter  int GUARD_BITS = 3,
  parameter  int SIGNED     = 0,
  parameter  int TAG_W      = 4,
  localparam int OWIDTH     = csa_owidth(WIDTH, GUARD_BITS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OWIDTH-1:0]         out_sum,
  output logic [OWIDTH-1:0]         out_carry,
  output logic [TAG_W-1:0]          out_tag
`ifdef CSA_FINAL_CPA_EN
  ,
  output logic [OWIDTH-1:0]         out_res
`endif
);

  localparam int L = csa_levels(NUM_IN);

  if (NUM_IN < MIN_IN || NUM_IN > MAX_IN) begin : g_bad_num_in
    $error("csa_tree_pipe: NUM_IN must lie in 3..9");
  end

  // Operand extension to OWIDTH; the signed path relies on the cast of a
  // signed value to sign-extend.
  logic [NUM_IN*OWIDTH-1:0] ext_data;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_ext
    if (SIGNED != 0) begin : g_sx
      logic signed [WIDTH-1:0] op_s;
      assign op_s = in_data[k*WIDTH +: WIDTH];
      assign ext_data[k*OWIDTH +: OWIDTH] = OWIDTH'(op_s);
    end else begin : g_zx
      assign ext_data[k*OWIDTH +: OWIDTH] = OWIDTH'(in_data[k*WIDTH +: WIDTH]);
    end
  end

  logic                    last_valid;
  logic                    last_ready;
  logic [2*OWIDTH-1:0]     last_data;
  logic [TAG_W-1:0]        last_tag;

  // Reduction chain; each level reads its predecessor's outputs and takes its
  // ready from its successor, so backpressure ripples combinationally.
  for (genvar i = 0; i < L; i++) begin : g_lvl
    localparam int N_I = csa_count_at(NUM_IN, i);
    localparam int N_O = csa_next_count(N_I);

    logic                 lv_in_valid;
    logic                 lv_in_ready;
    logic [N_I*OWIDTH-1:0] lv_in_data;
    logic [TAG_W-1:0]     lv_in_tag;
    logic                 lv_out_valid;
    logic                 lv_out_ready;
    logic [N_O*OWIDTH-1:0] lv_out_data;
    logic [TAG_W-1:0]     lv_out_tag;

    if (i == 0) begin : g_head
      assign lv_in_valid = in_valid;
      assign lv_in_data  = ext_data;
      assign lv_in_tag   = in_tag;
    end else begin : g_link
      assign lv_in_valid = g_lvl[i-1].lv_out_valid;
      assign lv_in_data  = g_lvl[i-1].lv_out_data;
      assign lv_in_tag   = g_lvl[i-1].lv_out_tag;
    end

    if (i == L - 1) begin : g_tail
      assign lv_out_ready = last_ready;
    end else begin : g_mid
      assign lv_out_ready = g_lvl[i+1].lv_in_ready;
    end

    csa_level #(
      .N_IN   (N_I),
      .OWIDTH (OWIDTH),
      .TAG_W  (TAG_W)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (lv_in_valid),
      .in_ready  (lv_in_ready),
      .in_data   (lv_in_data),
      .in_tag    (lv_in_tag),
      .out_valid (lv_out_valid),
      .out_ready (lv_out_ready),
      .out_data  (lv_out_data),
      .out_tag   (lv_out_tag)
    );
  end

  assign last_valid = g_lvl[L-1].lv_out_valid;
  assign last_data  = g_lvl[L-1].lv_out_data;
  assign last_tag   = g_lvl[L-1].lv_out_tag;

  // clr wins over any transfer, so nothing is accepted in the clear cycle.
  assign in_ready = !clr && g_lvl[0].lv_in_ready;

`ifdef CSA_FINAL_CPA_EN
  function automatic logic [OWIDTH-1:0] cpa_add(input logic [OWIDTH-1:0] a,
                                                input logic [OWIDTH-1:0] b);
    return a + b;
  endfunction

  // ---- stage p0: carry-propagate result, redundant pair kept aligned ----
  logic              vld_p0;
  logic [OWIDTH-1:0] sum_p0;
  logic [OWIDTH-1:0] carry_p0;
  logic [OWIDTH-1:0] res_p0;
  logic [TAG_W-1:0]  tag_p0;

  assign last_ready = !vld_p0 || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      sum_p0   <= '0;
      carry_p0 <= '0;
      res_p0   <= '0;
      tag_p0   <= '0;
    end else begin
      if (clr) begin
        vld_p0 <= 1'b0;
      end else if (last_ready) begin
        vld_p0 <= last_valid;
      end
      if (last_valid && last_ready) begin
        sum_p0   <= last_data[OWIDTH-1:0];
        carry_p0 <= last_data[2*OWIDTH-1:OWIDTH];
        res_p0   <= cpa_add(last_data[OWIDTH-1:0], last_data[2*OWIDTH-1:OWIDTH]);
        tag_p0   <= last_tag;
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_sum   = sum_p0;
  assign out_carry = carry_p0;
  assign out_res   = res_p0;
  assign out_tag   = tag_p0;
`else
  assign last_ready = out_ready;
  assign out_valid  = last_valid;
  assign out_sum    = last_data[OWIDTH-1:0];
  assign out_carry  = last_data[2*OWIDTH-1:OWIDTH];
  assign out_tag    = last_tag;
`endif

endmodule

// File: tb/tb_csa_tree_pipe.sv
// ---------------------------------------------------------------------------
// tb_csa_tree_pipe
//   Scoreboard bench for csa_tree_pipe. Three instances share clock, reset
//   and clear: an unsigned 5x8-bit tree, a signed 5x8-bit tree and an
//   unsigned 9x16-bit tree with four guard bits. Expected results are pushed
//   when a beat is accepted; a negedge monitor pops and compares whenever an
//   instance presents a result that is being taken.
//   Honours CSA_FINAL_CPA_EN (out_res checks, one extra cycle of latency).
// ---------------------------------------------------------------------------
module tb_csa_tree_pipe;

`ifdef CSA_FINAL_CPA_EN
  localparam int CPA = 1;
`else
  localparam int CPA = 0;
`endif
  localparam int LAT_M = 3 + CPA;

  typedef struct {
    logic [19:0] val;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  logic         m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [39:0]  m_in_data;
  logic [3:0]   m_in_tag, m_out_tag;
  logic [10:0]  m_out_sum, m_out_carry, m_tot;

  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [39:0]  s_in_data;
  logic [3:0]   s_in_tag, s_out_tag;
  logic [10:0]  s_out_sum, s_out_carry, s_tot;

  logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [143:0] w_in_data;
  logic [3:0]   w_in_tag, w_out_tag;
  logic [19:0]  w_out_sum, w_out_carry, w_tot;

`ifdef CSA_FINAL_CPA_EN
  logic [10:0]  m_out_res, s_out_res;
  logic [19:0]  w_out_res;
`endif

  assign m_tot = m_out_sum + m_out_carry;
  assign s_tot = s_out_sum + s_out_carry;
  assign w_tot = w_out_sum + w_out_carry;

  always #5 clk = ~clk;

  csa_tree_pipe #(.WIDTH(8), .NUM_IN(5), .GUARD_BITS(3), .SIGNED(0), .TAG_W(4)) u_main (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data), .in_tag(m_in_tag),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_sum(m_out_sum), .out_carry(m_out_carry), .out_tag(m_out_tag)
`ifdef CSA_FINAL_CPA_EN
    , .out_res(m_out_res)
`endif
  );

  csa_tree_pipe #(.WIDTH(8), .NUM_IN(5), .GUARD_BITS(3), .SIGNED(1), .TAG_W(4)) u_sgn (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_carry(s_out_carry), .out_tag(s_out_tag)
`ifdef CSA_FINAL_CPA_EN
    , .out_res(s_out_res)
`endif
  );

  csa_tree_pipe #(.WIDTH(16), .NUM_IN(9), .GUARD_BITS(4), .SIGNED(0), .TAG_W(4)) u_wide (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_sum(w_out_sum), .out_carry(w_out_carry), .out_tag(w_out_tag)
`ifdef CSA_FINAL_CPA_EN
    , .out_res(w_out_res)
`endif
  );

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  exp_t q_m[$];
  exp_t q_s[$];
  exp_t q_w[$];
  int   m_cyc_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Reference: plain unsigned sum of five bytes, modulo 2^11.
  function automatic logic [10:0] ref5(input logic [39:0] d);
    logic [10:0] s;
    s = '0;
    for (int k = 0; k < 5; k++) s = s + 11'(d[k*8 +: 8]);
    return s;
  endfunction

  task automatic push(input int id, input logic [19:0] e, input logic [3:0] t);
    exp_t x;
    x.val = e;
    x.tag = t;
    case (id)
      0:       q_m.push_back(x);
      1:       q_s.push_back(x);
      default: q_w.push_back(x);
    endcase
  endtask

  task automatic pop_cmp(input int id, input logic [19:0] tot, input logic [3:0] tag
`ifdef CSA_FINAL_CPA_EN
                         , input logic [19:0] res
`endif
                         );
    exp_t e;
    int   n;
    n = (id == 0) ? q_m.size() : (id == 1) ? q_s.size() : q_w.size();
    if (n == 0) begin
      n_total++;
      $display("FAIL unexpected_out[%0d]: got result 0x%0h, required no result", id, tot);
      return;
    end
    case (id)
      0:       e = q_m.pop_front();
      1:       e = q_s.pop_front();
      default: e = q_w.pop_front();
    endcase
    chk($sformatf("sum_plus_carry[%0d]", id), 32'(tot), 32'(e.val));
    chk($sformatf("tag[%0d]", id), 32'(tag), 32'(e.tag));
`ifdef CSA_FINAL_CPA_EN
    chk($sformatf("out_res[%0d]", id), 32'(res), 32'(e.val));
`endif
  endtask

  // Monitor: compare taken results, and check the main instance's held
  // output stays frozen while it is stalled.
  logic        hold_prev = 1'b0;
  logic [10:0] hold_sum, hold_carry;
  logic [3:0]  hold_tag;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev && m_out_valid) begin
        chk("hold_sum",   32'(m_out_sum),   32'(hold_sum));
        chk("hold_carry", 32'(m_out_carry), 32'(hold_carry));
        chk("hold_tag",   32'(m_out_tag),   32'(hold_tag));
      end
      hold_prev  <= m_out_valid && !m_out_ready;
      hold_sum   <= m_out_sum;
      hold_carry <= m_out_carry;
      hold_tag   <= m_out_tag;
      if (m_out_valid && m_out_ready) begin
        m_cyc_log.push_back(cyc);
`ifdef CSA_FINAL_CPA_EN
        pop_cmp(0, 20'(m_tot), m_out_tag, 20'(m_out_res));
`else
        pop_cmp(0, 20'(m_tot), m_out_tag);
`endif
      end
      if (s_out_valid && s_out_ready) begin
`ifdef CSA_FINAL_CPA_EN
        pop_cmp(1, 20'(s_tot), s_out_tag, 20'(s_out_res));
`else
        pop_cmp(1, 20'(s_tot), s_out_tag);
`endif
      end
      if (w_out_valid && w_out_ready) begin
`ifdef CSA_FINAL_CPA_EN
        pop_cmp(2, w_tot, w_out_tag, w_out_res);
`else
        pop_cmp(2, w_tot, w_out_tag);
`endif
      end
    end
  end

  // Present one beat and wait (bounded) for acceptance; returns 1 ns after
  // the accepting edge with in_valid dropped.
  task automatic send(input int id, input logic [143:0] d, input logic [3:0] t,
                      input logic [19:0] e);
    logic rdy;
    logic done;
    done = 1'b0;
    case (id)
      0:       begin m_in_data = d[39:0]; m_in_tag = t; m_in_valid = 1'b1; end
      1:       begin s_in_data = d[39:0]; s_in_tag = t; s_in_valid = 1'b1; end
      default: begin w_in_data = d;       w_in_tag = t; w_in_valid = 1'b1; end
    endcase
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      rdy = (id == 0) ? m_in_ready : (id == 1) ? s_in_ready : w_in_ready;
      if (rdy) begin
        push(id, e, t);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL send_timeout[%0d]: in_ready stayed 0, required 1", id);
    end
    m_in_valid = 1'b0;
    s_in_valid = 1'b0;
    w_in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q_m.size() + q_s.size() + q_w.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk(name, 32'(q_m.size() + q_s.size() + q_w.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [39:0] d40;
  logic [39:0] bp [0:7];
  int          idx;
  int          base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    m_in_valid = 1'b0; m_in_data = '0; m_in_tag = '0; m_out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_in_tag = '0; s_out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_data = '0; w_in_tag = '0; w_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(m_out_valid), 32'd0);
    chk("rst_out_sum",   32'(m_out_sum),   32'd0);
    chk("rst_out_carry", 32'(m_out_carry), 32'd0);
    chk("rst_out_tag",   32'(m_out_tag),   32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed: 1+2+3+4+5 = 15, tag 0xA, with latency check
    send(0, 144'({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}), 4'hA, 20'd15);
    repeat (LAT_M - 2) @(posedge clk);
    @(negedge clk);
    chk("latency_not_early", 32'(m_out_valid), 32'd0);
    @(negedge clk);
    chk("latency_on_time", 32'(m_out_valid), 32'd1);
    drain("drain_directed");

    // Signed extension boundaries and the wide nine-operand tree
    send(1, 144'({5{8'hFF}}), 4'h3, 20'h007FB);
    send(1, 144'({5{8'h80}}), 4'h4, 20'h00580);
    send(2, {9{16'hFFFF}}, 4'h5, 20'h8FFF7);
    send(0, 144'({5{8'h80}}), 4'h6, 20'h00280);
    drain("drain_signed_wide");

    // Back-to-back streaming of 20 random beats
    base = m_cyc_log.size();
    for (int i = 0; i < 20; i++) begin
      d40 = 40'({$urandom(), $urandom()});
      send(0, 144'(d40), 4'(i), 20'(ref5(d40)));
    end
    drain("drain_stream");
    chk("stream_count", 32'(m_cyc_log.size() - base), 32'd20);
    if (m_cyc_log.size() - base >= 20)
      chk("stream_one_per_cycle", 32'(m_cyc_log[base+19] - m_cyc_log[base]), 32'd19);

    // Backpressure: out_ready low for 6 cycles while input keeps offering
    for (int i = 0; i < 8; i++) bp[i] = 40'({$urandom(), $urandom()});
    m_out_ready = 1'b0;
    idx = 0;
    m_in_data = bp[0]; m_in_tag = 4'h0; m_in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (m_in_ready) begin
        push(0, 20'(ref5(bp[idx])), 4'(idx));
        idx++;
      end
      @(posedge clk);
      #1;
      m_in_data = bp[idx];
      m_in_tag  = 4'(idx);
    end
    @(negedge clk);
    chk("bp_in_ready_low", 32'(m_in_ready), 32'd0);
    chk("bp_accepted", 32'(idx), 32'(LAT_M));
    @(posedge clk);
    #1;
    m_out_ready = 1'b1;
    for (int j = idx; j < 8; j++) send(0, 144'(bp[j]), 4'(j), 20'(ref5(bp[j])));
    drain("drain_backpressure");

    // clr with three beats in flight
    send(0, 144'({8'd10, 8'd20, 8'd30, 8'd40, 8'd50}), 4'h1, 20'd150);
    send(0, 144'({8'd1, 8'd1, 8'd1, 8'd1, 8'd1}), 4'h2, 20'd5);
    send(0, 144'({8'd9, 8'd9, 8'd9, 8'd9, 8'd9}), 4'h3, 20'd45);
    clr = 1'b1;
    m_in_data = 40'h0102030405; m_in_tag = 4'hF; m_in_valid = 1'b1;
    @(negedge clk);
    chk("clr_in_ready_low", 32'(m_in_ready), 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    m_in_valid = 1'b0;
    q_m.delete();
    base = m_cyc_log.size();
    @(negedge clk);
    chk("clr_out_valid_low", 32'(m_out_valid), 32'd0);
    repeat (8) @(posedge clk);
    chk("clr_no_stale", 32'(m_cyc_log.size() - base), 32'd0);
    #1;

    // Asynchronous reset mid-stream with a result waiting at the output
    m_out_ready = 1'b0;
    m_in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_in_data = 40'({8'(i + 1), 8'd7, 8'd6, 8'd5, 8'd4});
      m_in_tag  = 4'(i + 8);
      @(posedge clk);
      #1;
    end
    m_in_valid = 1'b0;
    #2;
    chk("pre_reset_out_valid", 32'(m_out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(m_out_valid), 32'd0);
    chk("async_rst_out_sum",   32'(m_out_sum),   32'd0);
    chk("async_rst_out_carry", 32'(m_out_carry), 32'd0);
    chk("async_rst_out_tag",   32'(m_out_tag),   32'd0);
`ifdef CSA_FINAL_CPA_EN
    chk("async_rst_out_res",   32'(m_out_res),   32'd0);
`endif
    q_m.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_out_ready = 1'b1;

    // Recovery after reset: all-ones operands, 5*255 = 0x4FB
    send(0, 144'({5{8'hFF}}), 4'h7, 20'h004FB);
    drain("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
